// File: rtl/mult_div_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states
// and the default operand width.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mult_div_divstep.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module mult_div_divstep
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so a set top bit of the
  // (WIDTH+1)-bit difference can only mean the trial subtraction went negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (shift-add multiply, restoring divide), one bit
// per cycle. Define MULT_DIV_SIGNED_EN to make MULT/DIV signed; otherwise unsigned.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_next;
  op_e              op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] work_hi, work_lo;
  logic [CW-1:0]    cnt;
  logic             dz_reg;

  logic             req_is_div, req_div_zero, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_rem;
  logic             div_q;
  logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef MULT_DIV_SIGNED_EN
  logic             neg_a, neg_b;
  logic             req_signed;
  logic [2*WIDTH-1:0] prod_neg;
`endif

  // Operands are held as magnitudes; the sign work is deferred to FIX.
  always_comb begin
    req_is_div   = op[1];
    req_div_zero = req_is_div && (b_in == '0);
`ifdef MULT_DIV_SIGNED_EN
    req_signed = op[0];
    a_mag      = (req_signed && a_in[WIDTH-1]) ? -a_in : a_in;
    b_mag      = (req_signed && b_in[WIDTH-1]) ? -b_in : b_in;
`else
    a_mag = a_in;
    b_mag = b_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    div_zero   = 1'b0;
    case (state)
      IDLE: if (start) state_next = req_div_zero ? DONE : CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        done       = 1'b1;
        div_zero   = dz_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    is_div  = (op_reg == OP_DIVU) || (op_reg == OP_DIV);
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_reg} : '0);
  end

  mult_div_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (work_hi),
    .bit_in  (work_lo[WIDTH-1]),
    .divisor (b_reg),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  // Product: negate the full double-width value. Quotient truncates toward zero
  // and the remainder follows the dividend, so each half is negated on its own.
  always_comb begin
    fix_hi = work_hi;
    fix_lo = work_lo;
`ifdef MULT_DIV_SIGNED_EN
    prod_neg = -{work_hi, work_lo};
    if (op_reg == OP_MULT && (neg_a ^ neg_b)) begin
      {fix_hi, fix_lo} = prod_neg;
    end else if (op_reg == OP_DIV) begin
      if (neg_a ^ neg_b) fix_lo = -work_lo;
      if (neg_a)         fix_hi = -work_hi;
    end
`endif
  end

  // Multiply shifts the product right through work_hi:work_lo; divide shifts
  // the dividend out of work_lo while quotient bits fill it from the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg  <= OP_MULTU;
      a_reg   <= '0;
      b_reg   <= '0;
      work_hi <= '0;
      work_lo <= '0;
      cnt     <= '0;
      dz_reg  <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
`ifdef MULT_DIV_SIGNED_EN
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          op_reg  <= op_e'(op);
          a_reg   <= a_mag;
          b_reg   <= b_mag;
          work_hi <= '0;
          work_lo <= req_is_div ? a_mag : b_mag;
          cnt     <= '0;
          dz_reg  <= req_div_zero;
`ifdef MULT_DIV_SIGNED_EN
          neg_a   <= req_signed && a_in[WIDTH-1];
          neg_b   <= req_signed && b_in[WIDTH-1];
`endif
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            work_hi <= div_rem;
            work_lo <= {work_lo[WIDTH-2:0], div_q};
          end else begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_out <= fix_hi;
          lo_out <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WIDTH=32): arithmetic/latency reference model checked
// every cycle, plus directed literal checks. Honours MULT_DIV_SIGNED_EN.
module tb_mult_div_unit;

  localparam int W = 32;
`ifdef MULT_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    op;
  logic [W-1:0]  a_in, b_in;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  int          m_left = 0;
  bit          m_done = 1'b0, m_dz = 1'b0, was_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Plain arithmetic reference: 64-bit products, 64-bit signed division so the
  // most-negative / -1 case wraps naturally into 32 bits.
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    bit          sg;
    sg = SIGNED_EN && o[0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[1]) begin
      if (sg) p = sa * sb;
      else    p = {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else begin
      if (sg) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = longint'({32'b0, a} / {32'b0, b});
        r = longint'({32'b0, a} % {32'b0, b});
      end
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Transaction-level model: an accepted start yields done WIDTH+2 cycles later
  // (immediately for divide-by-zero); start is ignored until the cycle after done.
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      m_dz     = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_hi   = p_hi;
          m_lo   = p_lo;
        end
      end else if (start && !was_done) begin
        if (op[1] && b_in == '0) begin
          m_done = 1'b1;
          m_dz   = 1'b1;
        end else begin
          model_op(op, a_in, b_in, p_hi, p_lo);
          m_left = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_busy", 64'(busy), 64'((m_left > 0) || m_done));
      checkOutput("cyc_done", 64'(done), 64'(m_done));
      checkOutput("cyc_div_zero", 64'(div_zero), 64'(m_dz));
      checkOutput("cyc_hi", 64'(hi_out), 64'(m_hi));
      checkOutput("cyc_lo", 64'(lo_out), 64'(m_lo));
    end
  end

  // Called at a negedge with the unit idle. Returns after the cycle following done.
  task automatic applyStimulus(input logic [1:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input int glitch_at, output int lat, output logic [W-1:0] got_hi,
                               output logic [W-1:0] got_lo, output logic got_dz);
    op = op_v; a_in = a_v; b_in = b_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    op    = 2'($urandom);
    lat   = 1;
    while (!done && lat < 100) begin
      start = (lat == glitch_at);
      if (start) begin
        op   = 2'b10;
        b_in = '0;
      end
      @(negedge clk);
      lat++;
    end
    start  = 1'b0;
    got_hi = hi_out;
    got_lo = lo_out;
    got_dz = div_zero;
    if (!done) checkOutput("done_timeout", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int          lat, done_seen;
    logic [W-1:0] gh, gl;
    logic        gdz;

    reset = 1'b1; start = 1'b1; op = 2'b00; a_in = 32'd5; b_in = 32'd5;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi_lo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, gh, gl, gdz);
    checkOutput("multu_max_lat", 64'(lat), 64'd34);
    checkOutput("multu_max_hi", 64'(gh), 64'hFFFF_FFFE);
    checkOutput("multu_max_lo", 64'(gl), 64'h0000_0001);

    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7, 0, lat, gh, gl, gdz);
    checkOutput("mult_neg3x7", {gh, gl}, SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0000_0006_FFFF_FFEB);

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, gh, gl, gdz);
    checkOutput("mult_m1xm1", {gh, gl}, SIGNED_EN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001);

    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 0, lat, gh, gl, gdz);
    checkOutput("div_neg7by2", {gh, gl}, SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_7FFF_FFFC);

    applyStimulus(2'b10, 32'd100, 32'd7, 0, lat, gh, gl, gdz);
    checkOutput("divu_100by7", {gh, gl}, {32'd2, 32'd14});
    checkOutput("divu_100by7_lat", 64'(lat), 64'd34);

    applyStimulus(2'b10, 32'd100, 32'd0, 0, lat, gh, gl, gdz);
    checkOutput("divzero_flag", 64'(gdz), 64'd1);
    checkOutput("divzero_lat", 64'(lat), 64'd1);
    checkOutput("divzero_keep", {gh, gl}, {32'd2, 32'd14});

    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, gh, gl, gdz);
    checkOutput("div_ovf_flag", 64'(gdz), 64'd0);
    checkOutput("div_ovf", {gh, gl}, SIGNED_EN ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000);

    applyStimulus(2'b00, 32'd3, 32'd4, 7, lat, gh, gl, gdz);
    checkOutput("busy_glitch_result", {gh, gl}, 64'd12);
    checkOutput("busy_glitch_flag", 64'(gdz), 64'd0);

    applyStimulus(2'b10, 32'd5, 32'd9, 0, lat, gh, gl, gdz);
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 0, lat, gh, gl, gdz);
    applyStimulus(2'b11, 32'd7, 32'hFFFF_FFFE, 0, lat, gh, gl, gdz);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, (i == 2) ? 32'd0 : $urandom, 0, lat, gh, gl, gdz);
    end

    // Abort: a result is already latched; reset mid-operation must clear it.
    applyStimulus(2'b10, 32'd100, 32'd7, 0, lat, gh, gl, gdz);
    op = 2'b00; a_in = 32'd5; b_in = 32'd5; start = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi_lo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0; start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);

    applyStimulus(2'b00, 32'd5, 32'd5, 0, lat, gh, gl, gdz);
    checkOutput("after_abort_mul", {gh, gl}, 64'd25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
